mem_stage_sram: RTL and testbench



---
 rtl/mem_stage_sram_if.sv | 20 ++
 rtl/mem_stage_sram.sv | 133 +++++++++++++
 tb/tb_mem_stage_sram.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_sram_if.sv
// External 16-bit SRAM bus seen from the memory stage.
interface mem_stage_sram_if #(
  parameter int unsigned SRAM_AW = 18
);
  logic [SRAM_AW-1:0] sram_addr;
  logic [15:0]        sram_dq_out;
  logic               sram_dq_oe;
  logic [15:0]        sram_dq_in;
  logic               sram_we_n;

  modport master (
    output sram_addr, sram_dq_out, sram_dq_oe, sram_we_n,
    input  sram_dq_in
  );

  modport slave (
    input  sram_addr, sram_dq_out, sram_dq_oe, sram_we_n,
    output sram_dq_in
  );
endinterface

// File: rtl/mem_stage_sram.sv
// ARM pipeline memory stage: word LDR/STR as two half-word SRAM transfers, plus MEM/WB register.
// Optional macro SRAM_ADDR_CHECK_EN adds an address range check and a sticky addr_err output.
module mem_stage_sram #(
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned WAIT_CYCLES = 4,
  parameter int unsigned SRAM_AW     = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             WB_en_in,
  input  logic             MEM_r_en_in,
  input  logic             MEM_w_en_in,
  input  logic [31:0]      alu_res_in,
  input  logic [31:0]      val_rm_in,
  input  logic [3:0]       dest_in,
  output logic             ready,
  output logic             WB_en_out,
  output logic             MEM_r_en_out,
  output logic [31:0]      alu_res_out,
  output logic [31:0]      mem_data_out,
  output logic [3:0]       dest_out,
`ifdef SRAM_ADDR_CHECK_EN
  output logic             addr_err,
`endif
  mem_stage_sram_if.master sram
);

  typedef enum logic [1:0] {StIdle, StLo, StHi, StDone} state_e;

  localparam logic [3:0]  CntInit = 4'(WAIT_CYCLES - 1);
  localparam logic [31:0] Base    = 32'(BASE_ADDR);

  state_e             state;
  logic [3:0]         cnt;
  logic [15:0]        lo_reg, hi_reg;
  logic [SRAM_AW-1:0] addr_q;
  logic [15:0]        dq_out_q;
  logic               dq_oe_q, we_n_q;

  logic               req, is_store, is_load, req_go, oor;
  logic [SRAM_AW-2:0] word_idx;

  assign req      = MEM_r_en_in | MEM_w_en_in;
  assign is_store = MEM_w_en_in;
  assign is_load  = MEM_r_en_in & ~MEM_w_en_in;
  assign word_idx = (SRAM_AW-1)'((alu_res_in - Base) >> 2);

`ifdef SRAM_ADDR_CHECK_EN
  // Word index must fit in SRAM_AW-1 bits, i.e. byte offset below 2^(SRAM_AW+1).
  assign oor = (alu_res_in < Base) || (((alu_res_in - Base) >> (SRAM_AW + 1)) != 32'd0);
`else
  assign oor = 1'b0;
`endif

  assign req_go = req & ~oor;
  assign ready  = ((state == StIdle) && !req_go) || (state == StDone);

  assign sram.sram_addr   = addr_q;
  assign sram.sram_dq_out = dq_out_q;
  assign sram.sram_dq_oe  = dq_oe_q;
  assign sram.sram_we_n   = we_n_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= StIdle;
      cnt          <= 4'd0;
      lo_reg       <= 16'd0;
      hi_reg       <= 16'd0;
      addr_q       <= '0;
      dq_out_q     <= 16'd0;
      dq_oe_q      <= 1'b0;
      we_n_q       <= 1'b1;
      WB_en_out    <= 1'b0;
      MEM_r_en_out <= 1'b0;
      alu_res_out  <= 32'd0;
      mem_data_out <= 32'd0;
      dest_out     <= 4'd0;
`ifdef SRAM_ADDR_CHECK_EN
      addr_err     <= 1'b0;
`endif
    end else begin
      unique case (state)
        StIdle: begin
          if (req_go) begin
            state    <= StLo;
            cnt      <= CntInit;
            addr_q   <= {word_idx, 1'b0};
            we_n_q   <= ~is_store;
            dq_oe_q  <= is_store;
            dq_out_q <= is_store ? val_rm_in[15:0] : 16'd0;
          end
        end
        StLo: begin
          if (cnt == 4'd0) begin
            lo_reg <= sram.sram_dq_in;
            state  <= StHi;
            cnt    <= CntInit;
            addr_q <= {word_idx, 1'b1};
            if (is_store) dq_out_q <= val_rm_in[31:16];
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        StHi: begin
          if (cnt == 4'd0) begin
            hi_reg  <= sram.sram_dq_in;
            state   <= StDone;
            we_n_q  <= 1'b1;
            dq_oe_q <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        // Request deliberately not re-sampled here: the held instruction must not re-issue.
        StDone:  state <= StIdle;
        default: state <= StIdle;
      endcase

      if (ready) begin
        WB_en_out    <= WB_en_in;
        MEM_r_en_out <= MEM_r_en_in;
        alu_res_out  <= alu_res_in;
        dest_out     <= dest_in;
        if (is_load) mem_data_out <= oor ? 32'd0 : {hi_reg, lo_reg};
      end

`ifdef SRAM_ADDR_CHECK_EN
      if (req && oor) addr_err <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_mem_stage_sram.sv
// Directed self-checking bench for mem_stage_sram with a small behavioural SRAM.
module tb_mem_stage_sram;

  localparam int unsigned SramAw = 18;

  logic        clk = 1'b0;
  logic        rst;
  logic        WB_en_in, MEM_r_en_in, MEM_w_en_in;
  logic [31:0] alu_res_in, val_rm_in;
  logic [3:0]  dest_in;
  logic        ready, WB_en_out, MEM_r_en_out;
  logic [31:0] alu_res_out, mem_data_out;
  logic [3:0]  dest_out;
`ifdef SRAM_ADDR_CHECK_EN
  logic        addr_err;
`endif

  mem_stage_sram_if #(.SRAM_AW(SramAw)) sram_bus ();

  mem_stage_sram #(.BASE_ADDR(1024), .WAIT_CYCLES(4), .SRAM_AW(SramAw)) dut (
    .clk          (clk),
    .rst          (rst),
    .WB_en_in     (WB_en_in),
    .MEM_r_en_in  (MEM_r_en_in),
    .MEM_w_en_in  (MEM_w_en_in),
    .alu_res_in   (alu_res_in),
    .val_rm_in    (val_rm_in),
    .dest_in      (dest_in),
    .ready        (ready),
    .WB_en_out    (WB_en_out),
    .MEM_r_en_out (MEM_r_en_out),
    .alu_res_out  (alu_res_out),
    .mem_data_out (mem_data_out),
    .dest_out     (dest_out),
`ifdef SRAM_ADDR_CHECK_EN
    .addr_err     (addr_err),
`endif
    .sram         (sram_bus.master)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: 16 half-words, write on we_n low with oe.
  logic [15:0] mem [16];
  int          we_cycles = 0;
  int          oe_cycles = 0;

  assign sram_bus.sram_dq_in = mem[sram_bus.sram_addr[3:0]];

  always @(posedge clk) begin
    if (!sram_bus.sram_we_n) begin
      we_cycles <= we_cycles + 1;
      if (sram_bus.sram_dq_oe) mem[sram_bus.sram_addr[3:0]] <= sram_bus.sram_dq_out;
    end
    if (sram_bus.sram_dq_oe) oe_cycles <= oe_cycles + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wb, input logic rd, input logic wr, input logic [31:0] alu,
                       input logic [31:0] val, input logic [3:0] dst);
    WB_en_in    = wb;
    MEM_r_en_in = rd;
    MEM_w_en_in = wr;
    alu_res_in  = alu;
    val_rm_in   = val;
    dest_in     = dst;
    #1;
  endtask

  // Runs an access until ready rises (bounded); counts stall cycles, bus phases, MEM/WB holds.
  task automatic run_access(input logic [31:0] held_alu, input logic [15:0] lo_d,
                            input logic [15:0] hi_d, input logic [SramAw-1:0] base_half,
                            output int low, output int ph_lo, output int ph_hi,
                            output int hold_bad);
    low = 0; ph_lo = 0; ph_hi = 0; hold_bad = 0;
    while (!ready && low < 40) begin
      low++;
      if (alu_res_out !== held_alu) hold_bad++;
      step();
      if (!sram_bus.sram_we_n && sram_bus.sram_dq_oe) begin
        if (sram_bus.sram_addr == base_half && sram_bus.sram_dq_out == lo_d) ph_lo++;
        if (sram_bus.sram_addr == base_half + 1 && sram_bus.sram_dq_out == hi_d) ph_hi++;
      end
    end
  endtask

  int low, ph_lo, ph_hi, hold_bad;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
    mem[2] = 16'h1234;
    mem[3] = 16'hABCD;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    #2;
    check_eq("rst_ready", 32'(ready), 32'd1);
    check_eq("rst_we_n", 32'(sram_bus.sram_we_n), 32'd1);
    check_eq("rst_oe", 32'(sram_bus.sram_dq_oe), 32'd0);
    check_eq("rst_alu_out", alu_res_out, 32'd0);
    rst = 1'b0;
    step();

    // ADD: zero-latency pass-through
    drive(1'b1, 1'b0, 1'b0, 32'd7, 32'd0, 4'd3);
    check_eq("add_ready", 32'(ready), 32'd1);
    step();
    check_eq("add_alu_out", alu_res_out, 32'd7);
    check_eq("add_dest_out", 32'(dest_out), 32'd3);
    check_eq("add_wb_out", 32'(WB_en_out), 32'd1);

    // STR 0xDEADBEEF to 1024 -> half-addresses 0,1
    drive(1'b0, 1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 4'd0);
    run_access(32'd7, 16'hBEEF, 16'hDEAD, 0, low, ph_lo, ph_hi, hold_bad);
    check_eq("str_stall", 32'(low), 32'd9);
    check_eq("str_lo_phase", 32'(ph_lo), 32'd4);
    check_eq("str_hi_phase", 32'(ph_hi), 32'd4);
    check_eq("str_hold", 32'(hold_bad), 32'd0);
    check_eq("str_done_we_n", 32'(sram_bus.sram_we_n), 32'd1);
    step();
    check_eq("str_wb_alu", alu_res_out, 32'd1024);
    check_eq("str_wb_ren", 32'(MEM_r_en_out), 32'd0);

    // LDR from 1028 -> half-addresses 2,3, issued right after the store
    drive(1'b1, 1'b1, 1'b0, 32'd1028, 32'd0, 4'd5);
    run_access(32'd1024, 16'h0000, 16'h0000, 2, low, ph_lo, ph_hi, hold_bad);
    check_eq("ldr_stall", 32'(low), 32'd9);
    check_eq("ldr_hold", 32'(hold_bad), 32'd0);
    check_eq("ldr_pre_ren", 32'(MEM_r_en_out), 32'd0);
    step();
    check_eq("ldr_data", mem_data_out, 32'hABCD1234);
    check_eq("ldr_ren_out", 32'(MEM_r_en_out), 32'd1);
    check_eq("ldr_dest_out", 32'(dest_out), 32'd5);
    check_eq("ldr_wb_out", 32'(WB_en_out), 32'd1);

    // STR right after LDR, to 1032 -> half-addresses 4,5
    drive(1'b0, 1'b0, 1'b1, 32'd1032, 32'h55AA33CC, 4'd0);
    run_access(32'd1028, 16'h33CC, 16'h55AA, 4, low, ph_lo, ph_hi, hold_bad);
    check_eq("str2_stall", 32'(low), 32'd9);
    check_eq("str2_phases", 32'(ph_lo + ph_hi), 32'd8);
    step();
    check_eq("str2_data_hold", mem_data_out, 32'hABCD1234);
    check_eq("str2_wb_alu", alu_res_out, 32'd1032);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    step();
    check_eq("mem_w0", 32'(mem[0]), 32'h0000BEEF);
    check_eq("mem_w1", 32'(mem[1]), 32'h0000DEAD);
    check_eq("mem_w4", 32'(mem[4]), 32'h000033CC);
    check_eq("mem_w5", 32'(mem[5]), 32'h000055AA);
    check_eq("we_total", 32'(we_cycles), 32'd16);
    check_eq("oe_total", 32'(oe_cycles), 32'd16);

    // Reset asserted in the 3rd LO cycle of a store
    drive(1'b1, 1'b0, 1'b1, 32'd1040, 32'h11112222, 4'd9);
    step();
    step();
    step();
    check_eq("mid_we_n_pre", 32'(sram_bus.sram_we_n), 32'd0);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_ready", 32'(ready), 32'd0);
    check_eq("mid_rst_we_n", 32'(sram_bus.sram_we_n), 32'd1);
    check_eq("mid_rst_oe", 32'(sram_bus.sram_dq_oe), 32'd0);
    check_eq("mid_rst_dq", 32'(sram_bus.sram_dq_out), 32'd0);
    check_eq("mid_rst_addr", 32'(sram_bus.sram_addr), 32'd0);
    check_eq("mid_rst_data", mem_data_out, 32'd0);
    check_eq("mid_rst_alu", alu_res_out, 32'd0);
    check_eq("mid_rst_ctl", {26'd0, WB_en_out, MEM_r_en_out, dest_out}, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    check_eq("mid_rst_idle_ready", 32'(ready), 32'd1);
    step();
    rst = 1'b0;
    step();

`ifdef SRAM_ADDR_CHECK_EN
    drive(1'b1, 1'b1, 1'b0, 32'd100, 32'd0, 4'd2);
    check_eq("oor_ready", 32'(ready), 32'd1);
    step();
    check_eq("oor_we_n", 32'(sram_bus.sram_we_n), 32'd1);
    check_eq("oor_data", mem_data_out, 32'd0);
    check_eq("oor_err", 32'(addr_err), 32'd1);
    drive(1'b1, 1'b1, 1'b0, 32'd1028, 32'd0, 4'd2);
    run_access(32'd100, 16'h0000, 16'h0000, 2, low, ph_lo, ph_hi, hold_bad);
    step();
    check_eq("oor_legal_data", mem_data_out, 32'hABCD1234);
    check_eq("oor_err_sticky", 32'(addr_err), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
